// File: rtl/riscv_regfile_wb_arb.sv
// Register-file write-port arbiter: grants ALU or LSU writeback each cycle and
// drives the single write port from registers. It also counts contention cycles.
module riscv_regfile_wb_arb #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned ADDR_W     = 5,
  parameter int unsigned FIXED_PRIO = 0,
  parameter int unsigned CNT_W      = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              alu_valid_i,
  input  logic [ADDR_W-1:0] alu_rd_i,
  input  logic [DATA_W-1:0] alu_value_i,
  output logic              alu_ready_o,
  input  logic              lsu_valid_i,
  input  logic [ADDR_W-1:0] lsu_rd_i,
  input  logic [DATA_W-1:0] lsu_value_i,
  output logic              lsu_ready_o,
  output logic              wr_o,
  output logic [ADDR_W-1:0] rd0_o,
  output logic [DATA_W-1:0] rd0_value_o,
  output logic [1:0]        grant_o,
  output logic [CNT_W-1:0]  conflict_cnt_o
);

  typedef enum logic {SRC_ALU = 1'b0, SRC_LSU = 1'b1} src_e;

  src_e              last_q, last_d;
  logic              wr_q, wr_d;
  logic [ADDR_W-1:0] rd_q, rd_d;
  logic [DATA_W-1:0] val_q, val_d;
  logic [1:0]        grant_q, grant_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              contend;
  logic              alu_wins;

  // ready is withheld during reset so a pending request survives into the first normal cycle
  always_comb begin
    contend     = alu_valid_i && lsu_valid_i;
    alu_wins    = (FIXED_PRIO != 0) || (last_q == SRC_LSU);
    alu_ready_o = 1'b0;
    lsu_ready_o = 1'b0;
    if (!rst_i) begin
      if (contend) begin
        alu_ready_o = alu_wins;
        lsu_ready_o = !alu_wins;
      end else begin
        alu_ready_o = alu_valid_i;
        lsu_ready_o = lsu_valid_i;
      end
    end
  end

  always_comb begin
    last_d  = last_q;
    wr_d    = 1'b0;
    rd_d    = rd_q;
    val_d   = val_q;
    grant_d = 2'b00;
    cnt_d   = cnt_q;
    if (contend) begin
      last_d = alu_wins ? SRC_ALU : SRC_LSU;
      if (cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
    end
    if (alu_ready_o) begin
      wr_d    = (alu_rd_i != '0);
      rd_d    = alu_rd_i;
      val_d   = alu_value_i;
      grant_d = 2'b01;
    end else if (lsu_ready_o) begin
      wr_d    = (lsu_rd_i != '0);
      rd_d    = lsu_rd_i;
      val_d   = lsu_value_i;
      grant_d = 2'b10;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      last_q  <= SRC_LSU;
      wr_q    <= 1'b0;
      rd_q    <= '0;
      val_q   <= '0;
      grant_q <= 2'b00;
      cnt_q   <= '0;
    end else begin
      last_q  <= last_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      val_q   <= val_d;
      grant_q <= grant_d;
      cnt_q   <= cnt_d;
    end
  end

  assign wr_o           = wr_q;
  assign rd0_o          = rd_q;
  assign rd0_value_o    = val_q;
  assign grant_o        = grant_q;
  assign conflict_cnt_o = cnt_q;

endmodule

// File: tb/tb_riscv_regfile_wb_arb.sv
// Bench for riscv_regfile_wb_arb: vector table, directed corner sequences,
// and random traffic against a rule-level reference model.
module tb_riscv_regfile_wb_arb;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  // Round-robin instance, default widths
  logic        rst = 1'b1;
  logic        av = 1'b0, lv = 1'b0;
  logic [4:0]  ard = '0, lrd = '0;
  logic [31:0] aval = '0, lval = '0;
  logic        ar, lr, wr;
  logic [4:0]  rd0;
  logic [31:0] rd0v;
  logic [1:0]  gnt;
  logic [15:0] cnt;

  // Fixed-priority instance with a 3-bit counter
  logic        b_rst = 1'b1;
  logic        b_av = 1'b0, b_lv = 1'b0;
  logic [4:0]  b_ard = '0, b_lrd = '0;
  logic [31:0] b_aval = '0, b_lval = '0;
  logic        b_ar, b_lr, b_wr;
  logic [4:0]  b_rd0;
  logic [31:0] b_rd0v;
  logic [1:0]  b_gnt;
  logic [2:0]  b_cnt;

  riscv_regfile_wb_arb #(.DATA_W(32), .ADDR_W(5), .FIXED_PRIO(0), .CNT_W(16)) dut (
    .clk_i(clk), .rst_i(rst),
    .alu_valid_i(av), .alu_rd_i(ard), .alu_value_i(aval), .alu_ready_o(ar),
    .lsu_valid_i(lv), .lsu_rd_i(lrd), .lsu_value_i(lval), .lsu_ready_o(lr),
    .wr_o(wr), .rd0_o(rd0), .rd0_value_o(rd0v), .grant_o(gnt), .conflict_cnt_o(cnt)
  );

  riscv_regfile_wb_arb #(.DATA_W(32), .ADDR_W(5), .FIXED_PRIO(1), .CNT_W(3)) dut_fp (
    .clk_i(clk), .rst_i(b_rst),
    .alu_valid_i(b_av), .alu_rd_i(b_ard), .alu_value_i(b_aval), .alu_ready_o(b_ar),
    .lsu_valid_i(b_lv), .lsu_rd_i(b_lrd), .lsu_value_i(b_lval), .lsu_ready_o(b_lr),
    .wr_o(b_wr), .rd0_o(b_rd0), .rd0_value_o(b_rd0v), .grant_o(b_gnt), .conflict_cnt_o(b_cnt)
  );

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: state of the round-robin write port after the last edge
  bit          m_wr = 0;
  bit [4:0]    m_rd = 0;
  bit [31:0]   m_val = 0;
  bit [1:0]    m_gnt = 0;
  int          m_cnt = 0;
  bit          m_prev_lsu = 1;   // who won the previous contention
  logic        e_ar, e_lr;

  function automatic void predict(output logic pa, output logic pl);
    pa = 1'b0;
    pl = 1'b0;
    if (!rst) begin
      if (av && lv) begin
        if (m_prev_lsu) pa = 1'b1;
        else pl = 1'b1;
      end else begin
        pa = av;
        pl = lv;
      end
    end
  endfunction

  task automatic cycle();
    @(negedge clk);
    predict(e_ar, e_lr);
    chk("alu_ready", ar, e_ar);
    chk("lsu_ready", lr, e_lr);
    chk("wr", wr, m_wr);
    chk("rd0", rd0, m_rd);
    chk("rd0_value", rd0v, m_val);
    chk("grant", gnt, m_gnt);
    chk("conflict_cnt", cnt, m_cnt);
    @(posedge clk);
    if (rst) begin
      m_wr = 0; m_rd = 0; m_val = 0; m_gnt = 0; m_cnt = 0; m_prev_lsu = 1;
    end else begin
      if (av && lv) begin
        if (m_cnt < 65535) m_cnt++;
        m_prev_lsu = e_lr;
      end
      if (e_ar) begin
        m_wr = (ard != 0); m_rd = ard; m_val = aval; m_gnt = 2'b01;
      end else if (e_lr) begin
        m_wr = (lrd != 0); m_rd = lrd; m_val = lval; m_gnt = 2'b10;
      end else begin
        m_wr = 0; m_gnt = 0;
      end
    end
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; av = 1'b0; lv = 1'b0;
    cycle();
    rst = 1'b0;
  endtask

  typedef struct {
    logic        av;  logic [4:0] ard; logic [31:0] aval;
    logic        lv;  logic [4:0] lrd; logic [31:0] lval;
    logic        ear; logic       elr;
    logic        ewr; logic [4:0] erd; logic [31:0] eval; logic [1:0] egr;
  } vec_t;

  vec_t tbl[8];
  int   order[$];
  int   exp_rr[8] = '{1, 9, 2, 10, 3, 11, 4, 12};
  int   exp_fp[8] = '{1, 2, 3, 4, 9, 10, 11, 12};

  initial begin
    tbl[0] = '{1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0,  32'h0,    1'b1, 1'b0, 1'b1, 5'd5,  32'hDEADBEEF, 2'b01};
    tbl[1] = '{1'b0, 5'd0, 32'h0,        1'b1, 5'd0,  32'h1234, 1'b0, 1'b1, 1'b0, 5'd0,  32'h1234,     2'b10};
    tbl[2] = '{1'b1, 5'd3, 32'h33,       1'b1, 5'd7,  32'h77,   1'b1, 1'b0, 1'b1, 5'd3,  32'h33,       2'b01};
    tbl[3] = '{1'b1, 5'd4, 32'h44,       1'b1, 5'd7,  32'h77,   1'b0, 1'b1, 1'b1, 5'd7,  32'h77,       2'b10};
    tbl[4] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0,  32'h0,    1'b0, 1'b0, 1'b0, 5'd7,  32'h77,       2'b00};
    tbl[5] = '{1'b1, 5'd8, 32'h88,       1'b0, 5'd0,  32'h0,    1'b1, 1'b0, 1'b1, 5'd8,  32'h88,       2'b01};
    tbl[6] = '{1'b1, 5'd9, 32'h99,       1'b1, 5'd10, 32'hAA,   1'b1, 1'b0, 1'b1, 5'd9,  32'h99,       2'b01};
    tbl[7] = '{1'b0, 5'd0, 32'h0,        1'b1, 5'd10, 32'hAA,   1'b0, 1'b1, 1'b1, 5'd10, 32'hAA,       2'b10};

    // Reset held with both requesting: nothing accepted, ALU first afterwards
    rst = 1'b1; av = 1'b1; lv = 1'b1; ard = 5'd6; lrd = 5'd14; aval = 32'h66; lval = 32'hEE;
    cycle();
    cycle();
    rst = 1'b0;
    cycle();
    chk("first_grant_after_reset", gnt, 2'b01);
    chk("first_rd_after_reset", rd0, 5'd6);

    // Vector table
    do_reset();
    for (int i = 0; i < 8; i++) begin
      av = tbl[i].av; ard = tbl[i].ard; aval = tbl[i].aval;
      lv = tbl[i].lv; lrd = tbl[i].lrd; lval = tbl[i].lval;
      #1;
      chk($sformatf("tbl%0d_alu_ready", i), ar, tbl[i].ear);
      chk($sformatf("tbl%0d_lsu_ready", i), lr, tbl[i].elr);
      cycle();
      chk($sformatf("tbl%0d_wr", i), wr, tbl[i].ewr);
      chk($sformatf("tbl%0d_rd0", i), rd0, tbl[i].erd);
      chk($sformatf("tbl%0d_value", i), rd0v, tbl[i].eval);
      chk($sformatf("tbl%0d_grant", i), gnt, tbl[i].egr);
    end
    av = 1'b0; lv = 1'b0;
    cycle();
    chk("tbl_wr_drops", wr, 1'b0);
    chk("tbl_conflicts", cnt, 16'd3);

    // Continuous contention, round-robin ordering
    do_reset();
    begin
      int ai = 0, li = 0;
      order.delete();
      for (int n = 0; n < 20 && (ai < 4 || li < 4); n++) begin
        av = (ai < 4); ard = 5'(1 + ai); aval = 32'(100 + ai);
        lv = (li < 4); lrd = 5'(9 + li); lval = 32'(200 + li);
        cycle();
        if (e_ar) ai++;
        if (e_lr) li++;
        if (wr) order.push_back(int'(rd0));
      end
      chk("rr_cnt_after_last", cnt, 16'd7);
      av = 1'b0; lv = 1'b0;
      chk("rr_write_count", order.size(), 8);
      for (int k = 0; k < 8 && k < order.size(); k++)
        chk($sformatf("rr_order%0d", k), order[k], exp_rr[k]);
    end

    // Random traffic with holding requesters and occasional reset
    begin
      bit apend = 0, lpend = 0;
      for (int n = 0; n < 400; n++) begin
        if (!apend && ($urandom % 3 != 0)) begin
          apend = 1;
          ard   = ($urandom % 4 == 0) ? 5'd0 : 5'($urandom);
          aval  = $urandom;
        end
        if (!lpend && ($urandom % 3 != 0)) begin
          lpend = 1;
          lrd   = ($urandom % 4 == 0) ? 5'd0 : 5'($urandom);
          lval  = $urandom;
        end
        av  = apend;
        lv  = lpend;
        rst = ($urandom % 60 == 0);
        cycle();
        if (e_ar) apend = 0;
        if (e_lr) lpend = 0;
      end
      rst = 1'b0; av = 1'b0; lv = 1'b0;
      cycle();
    end

    // Fixed priority: LSU waits for all ALU writes; counter saturates at 7
    b_rst = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    b_rst = 1'b0;
    begin
      int ai = 0, li = 0;
      logic sa, sl;
      order.delete();
      for (int n = 0; n < 20 && (ai < 4 || li < 4); n++) begin
        b_av = (ai < 4); b_ard = 5'(1 + ai); b_aval = 32'(ai);
        b_lv = (li < 4); b_lrd = 5'(9 + li); b_lval = 32'(li);
        @(negedge clk);
        sa = b_ar; sl = b_lr;
        @(posedge clk); #1;
        if (sa) ai++;
        if (sl) li++;
        if (b_wr) order.push_back(int'(b_rd0));
      end
      chk("fp_write_count", order.size(), 8);
      for (int k = 0; k < 8 && k < order.size(); k++)
        chk($sformatf("fp_order%0d", k), order[k], exp_fp[k]);
      chk("fp_cnt_after_order", b_cnt, 3'd4);
      b_av = 1'b1; b_lv = 1'b1; b_ard = 5'd2; b_lrd = 5'd3;
      for (int n = 0; n < 10; n++) begin
        @(negedge clk);
        if (n == 0) chk("fp_lsu_starved", b_lr, 1'b0);
        @(posedge clk); #1;
      end
      chk("fp_cnt_saturated", b_cnt, 3'd7);
      b_av = 1'b0; b_lv = 1'b0;
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
